// File: rtl/arb_pkg.sv
// Shared types and the rotating-priority search for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Scans req starting at ptr and wrapping modulo N_REQ. The scan runs from the
  // farthest offset down so the closest set bit is the last (winning) write.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                    input logic [IDX_W-1:0] ptr);
    pick_t            p;
    logic [IDX_W-1:0] j;
    p = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = ptr + IDX_W'(k);
      if (req[j]) begin
        p.found = 1'b1;
        p.idx   = j;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/decoder_3x8.sv
// 3-to-8 one-hot decoder; (a, b, c) form the index MSB-first.
module decoder_3x8 (
  input  logic       a,
  input  logic       b,
  input  logic       c,
  output logic [7:0] y
);

  assign y = 8'b0000_0001 << {a, b, c};

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with release-on-done, release-on-drop and
// an optional hold limit. One IDLE cycle always separates consecutive grants.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam logic [7:0] HOLD_LAST = 8'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [7:0]       hold_cnt;
  logic [N_REQ-1:0] dec_y;

  pick_t pick;
  logic  owner_drop;
  logic  limit_hit;
  logic  release_now;

  assign pick        = rr_pick(req, ptr);
  assign owner_drop  = ~req[gnt_idx];
  assign limit_hit   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  assign release_now = done | owner_drop | limit_hit;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick.found) begin
            gnt_idx   <= pick.idx;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
            state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (release_now) begin
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + 1'b1;
            // A limit release that coincides with done or a drop is a normal release.
            timeout   <= limit_hit & ~done & ~owner_drop;
            state     <= ST_IDLE;
          end else if (hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  decoder_3x8 u_dec (
    .a (gnt_idx[2]),
    .b (gnt_idx[1]),
    .c (gnt_idx[0]),
    .y (dec_y)
  );

  assign gnt = gnt_valid ? dec_y : '0;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Randomized scoreboard bench for rr_arbiter_8 against a per-cycle reference model.
module tb_rr_arbiter_8;

  localparam int H = 4;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  rr_arbiter_8 #(.MAX_HOLD(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: who owns the resource, for how many cycles, and where
  // the next search starts.
  bit m_busy  = 0;
  int m_owner = 0;
  int m_held  = 0;
  int m_start = 0;
  int m_last  = 0;
  bit m_to    = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_edge(input logic [7:0] r, input logic d, input logic rs);
    exp_t e;
    if (rs) begin
      m_busy = 0; m_held = 0; m_start = 0; m_last = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (!m_busy) begin
        for (int k = 0; k < 8; k++) begin
          int j;
          j = (m_start + k) % 8;
          if (r[j]) begin
            m_busy = 1; m_owner = j; m_last = j; m_held = 1;
            break;
          end
        end
      end else begin
        bit lim, drop;
        lim  = (H != 0) && (m_held == H);
        drop = !r[m_owner];
        if (d || drop || lim) begin
          m_busy  = 0;
          m_start = (m_owner + 1) % 8;
          m_to    = lim && !d && !drop;
        end else begin
          m_held++;
        end
      end
    end
    e.gnt = m_busy ? (8'd1 << m_owner) : 8'd0;
    e.idx = 3'(m_last);
    e.vld = m_busy;
    e.to  = m_to;
    exp_q.push_back(e);
  endtask

  // Apply inputs for one cycle, predict the post-edge outputs, return at negedge.
  task automatic cycle(input logic [7:0] r, input logic d, input logic rs);
    req  = r;
    done = d;
    rst  = rs;
    @(posedge clk);
    model_edge(r, d, rs);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("gnt",       int'(gnt),       int'(e.gnt));
      check("gnt_idx",   int'(gnt_idx),   int'(e.idx));
      check("gnt_valid", int'(gnt_valid), int'(e.vld));
      check("timeout",   int'(timeout),   int'(e.to));
    end
  end

  initial begin
    req  = 8'hFF;
    done = 1'b0;
    rst  = 1'b1;

    // Reset with all requests pending, then first grant to idx 0.
    repeat (3) cycle(8'hFF, 1'b0, 1'b1);
    cycle(8'hFF, 1'b0, 1'b0);

    // Full rotation 0..7,0 with done after 2 grant cycles.
    for (int g = 0; g < 9; g++) begin
      cycle(8'hFF, 1'b0, 1'b0);
      cycle(8'hFF, 1'b1, 1'b0);
      cycle(8'hFF, 1'b0, 1'b0);
    end

    // Steer ptr to 3 via a grant to idx 2, then show wrap 7 -> 2.
    cycle(8'h00, 1'b0, 1'b0);
    cycle(8'h04, 1'b0, 1'b0);
    cycle(8'h04, 1'b1, 1'b0);
    cycle(8'h84, 1'b0, 1'b0);
    cycle(8'h84, 1'b1, 1'b0);
    cycle(8'h84, 1'b0, 1'b0);
    cycle(8'h84, 1'b1, 1'b0);
    cycle(8'h00, 1'b0, 1'b0);

    // Hold limit: requester 5 alone, never done; regranted after the bubble.
    repeat (12) cycle(8'h20, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b0);

    // done coincides with the limit cycle: no timeout.
    cycle(8'h20, 1'b0, 1'b0);
    repeat (3) cycle(8'h20, 1'b0, 1'b0);
    cycle(8'h20, 1'b1, 1'b0);
    cycle(8'h00, 1'b0, 1'b0);

    // Owner drops its request mid-grant.
    cycle(8'h08, 1'b0, 1'b0);
    cycle(8'h08, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b0);

    // Reset during grant at hold_cnt = 2, then reset priority applies.
    cycle(8'h41, 1'b0, 1'b0);
    cycle(8'h41, 1'b1, 1'b0);
    cycle(8'h41, 1'b0, 1'b0);
    cycle(8'h41, 1'b0, 1'b0);
    cycle(8'h41, 1'b0, 1'b0);
    cycle(8'h41, 1'b0, 1'b1);
    cycle(8'h41, 1'b0, 1'b0);
    cycle(8'h41, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] r;
      logic       d, rs;
      r  = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
      d  = ($urandom_range(0, 4) == 0);
      rs = ($urandom_range(0, 199) == 0);
      cycle(r, d, rs);
    end

    cycle(8'h00, 1'b0, 1'b0);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
